openram_scan_master: RTL

Host-side driver for the OpenRAM test chip's serial scan interface. It takes one parallel SRAM access request and serializes it MSB-first onto the scan pins. It then pulses the SRAM load strobe, waits for the chip to capture read data, shifts the 112-bit chain back out, and returns both read words on a valid/ready response port. It sits on the tester/FPGA side opposite the chip's `gpio_scan`/`gpio_in`/`gpio_sram_load`/`gpio_global_csb`/`gpio_out` pins, sharing the chip clock.

---
 rtl/openram_scan_pkg.sv | 54 +++++
 rtl/scan_shift_reg.sv | 31 +++
 rtl/openram_scan_master.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/openram_scan_pkg.sv
// Shared definitions for the OpenRAM scan-chain host driver: default widths, chain
// field offsets, request packing and the controller state encoding.
package openram_scan_pkg;

  localparam int unsigned DEF_ADDR_SIZE      = 16;
  localparam int unsigned DEF_DATA_SIZE      = 32;
  localparam int unsigned DEF_WMASK_SIZE     = 4;
  localparam int unsigned DEF_SEL_SIZE       = 4;
  localparam int unsigned DEF_CAPTURE_CYCLES = 2;

  // One port's slice of the chain: {addr, din, csb, web, wmask}
  localparam int unsigned PORT_LEN = DEF_ADDR_SIZE + DEF_DATA_SIZE + 2 + DEF_WMASK_SIZE;
  localparam int unsigned SCAN_LEN = DEF_SEL_SIZE + 2 * PORT_LEN;

  localparam int unsigned WMASK1_LSB = 0;
  localparam int unsigned WEB1_BIT   = DEF_WMASK_SIZE;
  localparam int unsigned CSB1_BIT   = DEF_WMASK_SIZE + 1;
  localparam int unsigned DIN1_LSB   = DEF_WMASK_SIZE + 2;
  localparam int unsigned DIN1_MSB   = DIN1_LSB + DEF_DATA_SIZE - 1;
  localparam int unsigned ADDR1_LSB  = DIN1_MSB + 1;
  localparam int unsigned WMASK0_LSB = PORT_LEN;
  localparam int unsigned WEB0_BIT   = PORT_LEN + DEF_WMASK_SIZE;
  localparam int unsigned CSB0_BIT   = PORT_LEN + DEF_WMASK_SIZE + 1;
  localparam int unsigned DIN0_LSB   = PORT_LEN + DEF_WMASK_SIZE + 2;
  localparam int unsigned DIN0_MSB   = DIN0_LSB + DEF_DATA_SIZE - 1;
  localparam int unsigned ADDR0_LSB  = DIN0_MSB + 1;
  localparam int unsigned SEL_LSB    = 2 * PORT_LEN;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StLoad,
    StCapture,
    StShiftOut,
    StResp
  } scan_state_e;

  function automatic logic [SCAN_LEN-1:0] pack_req(
    input logic [DEF_SEL_SIZE-1:0]   sel,
    input logic [DEF_ADDR_SIZE-1:0]  addr0,
    input logic [DEF_DATA_SIZE-1:0]  din0,
    input logic                      csb0,
    input logic                      web0,
    input logic [DEF_WMASK_SIZE-1:0] wmask0,
    input logic [DEF_ADDR_SIZE-1:0]  addr1,
    input logic [DEF_DATA_SIZE-1:0]  din1,
    input logic                      csb1,
    input logic                      web1,
    input logic [DEF_WMASK_SIZE-1:0] wmask1
  );
    return {sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1};
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Chain-length shift register: parallel load, left shift with serial-in at the LSB,
// serial-out at the MSB.
module scan_shift_reg #(
  parameter int unsigned Width = 112
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= {data_q[Width-2:0], serial_i};
    end
  end

  assign serial_o = data_q[Width-1];
  assign q_o      = data_q;

endmodule

// File: rtl/openram_scan_master.sv
// Host-side OpenRAM scan master: serializes one dual-port SRAM request, strobes the
// load, waits for capture, shifts the chain back and returns both read words.
module openram_scan_master
  import openram_scan_pkg::*;
#(
  parameter int unsigned ADDR_SIZE      = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE      = DEF_DATA_SIZE,
  parameter int unsigned WMASK_SIZE     = DEF_WMASK_SIZE,
  parameter int unsigned SEL_SIZE       = DEF_SEL_SIZE,
  parameter int unsigned CAPTURE_CYCLES = DEF_CAPTURE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_SIZE-1:0]   req_sel,
  input  logic [ADDR_SIZE-1:0]  req_addr0,
  input  logic [DATA_SIZE-1:0]  req_din0,
  input  logic                  req_csb0,
  input  logic                  req_web0,
  input  logic [WMASK_SIZE-1:0] req_wmask0,
  input  logic [ADDR_SIZE-1:0]  req_addr1,
  input  logic [DATA_SIZE-1:0]  req_din1,
  input  logic                  req_csb1,
  input  logic                  req_web1,
  input  logic [WMASK_SIZE-1:0] req_wmask1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_SIZE-1:0]  rsp_dout0,
  output logic [DATA_SIZE-1:0]  rsp_dout1,
  output logic                  scan_en_o,
  output logic                  scan_data_o,
  input  logic                  scan_data_i,
  output logic                  sram_load_o,
  output logic                  global_csb_o,
  output logic                  busy_o
);

  localparam int unsigned PortLen = ADDR_SIZE + DATA_SIZE + 2 + WMASK_SIZE;
  localparam int unsigned ScanLen = SEL_SIZE + 2 * PortLen;
  localparam int unsigned CntW    = $clog2(ScanLen);
  localparam int unsigned Din1Lsb = WMASK_SIZE + 2;
  localparam int unsigned Din0Lsb = PortLen + WMASK_SIZE + 2;
  localparam logic [CntW-1:0] LastBit = CntW'(ScanLen - 1);
  localparam logic [CntW-1:0] CapLast = CntW'((CAPTURE_CYCLES == 0) ? 0 : CAPTURE_CYCLES - 1);

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            scan_en_q, scan_en_d;
  logic            scan_data_q, scan_data_d;
  logic            sram_load_q, sram_load_d;
  logic            global_csb_q, global_csb_d;

  logic               sreg_load, sreg_shift, sreg_serial_in, sreg_msb, next_msb, counting;
  logic [ScanLen-1:0] req_vec, sreg_q;
  logic               unused_sreg;

  assign req_vec = {req_sel, req_addr0, req_din0, req_csb0, req_web0, req_wmask0,
                    req_addr1, req_din1, req_csb1, req_web1, req_wmask1};

  scan_shift_reg #(
    .Width(ScanLen)
  ) u_sreg (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (sreg_load),
    .load_data_i(req_vec),
    .shift_i    (sreg_shift),
    .serial_i   (sreg_serial_in),
    .serial_o   (sreg_msb),
    .q_o        (sreg_q)
  );

  always_comb begin
    state_d        = state_q;
    sreg_load      = 1'b0;
    sreg_shift     = 1'b0;
    sreg_serial_in = 1'b0;
    counting       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          sreg_load = 1'b1;
          state_d   = StShiftIn;
        end
      end
      StShiftIn: begin
        sreg_shift = 1'b1;
        counting   = 1'b1;
        if (cnt_q == LastBit) state_d = StLoad;
      end
      StLoad: begin
        state_d = (CAPTURE_CYCLES == 0) ? StShiftOut : StCapture;
      end
      StCapture: begin
        counting = 1'b1;
        if (cnt_q == CapLast) state_d = StShiftOut;
      end
      StShiftOut: begin
        sreg_shift     = 1'b1;
        sreg_serial_in = scan_data_i;
        counting       = 1'b1;
        if (cnt_q == LastBit) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Pins are registered from the next state so they line up with the shift register.
    next_msb     = sreg_load ? req_vec[ScanLen-1] :
                   sreg_shift ? sreg_q[ScanLen-2] : sreg_msb;
    scan_en_d    = (state_d == StShiftIn) || (state_d == StShiftOut);
    scan_data_d  = (state_d == StShiftIn) && next_msb;
    sram_load_d  = (state_d == StLoad);
    global_csb_d = !((state_d == StLoad) || (state_d == StCapture));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      scan_en_q    <= 1'b0;
      scan_data_q  <= 1'b0;
      sram_load_q  <= 1'b0;
      global_csb_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_en_q    <= scan_en_d;
      scan_data_q  <= scan_data_d;
      sram_load_q  <= sram_load_d;
      global_csb_q <= global_csb_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_dout0    = rsp_valid ? sreg_q[Din0Lsb +: DATA_SIZE] : '0;
  assign rsp_dout1    = rsp_valid ? sreg_q[Din1Lsb +: DATA_SIZE] : '0;
  assign scan_en_o    = scan_en_q;
  assign scan_data_o  = scan_data_q;
  assign sram_load_o  = sram_load_q;
  assign global_csb_o = global_csb_q;

  // Only the data fields are read back; the rest of the chain is don't-care here.
  assign unused_sreg = ^sreg_q;

endmodule
